ahb_sram_slave: RTL

AHB-Lite slave wrapping a synchronous word-organised SRAM. It is the downstream consumer of the bus master's HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA and produces HRDATA/HREADY/HRESP back to it. It supports programmable wait states, byte/halfword/word accesses and two-cycle ERROR responses. Its bus behaviour is identical for single and burst beats, with no burst reordering.

---
 rtl/ahb_sram_slave.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-wide SRAM: programmable wait states, byte/half/word lanes, two-cycle ERROR.
// Define AHB_SRAM_STATS_EN to build the saturating read/write/error statistics counters.
module ahb_sram_slave #(
   parameter int          MEM_AW      = 8,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [15:0] stat_rd_cnt,
   output logic [15:0] stat_wr_cnt,
   output logic [15:0] stat_err_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
   localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

   state_t            r_state;
   logic [MEM_AW+1:0] r_addr;
   logic              r_write;
   logic [1:0]        r_size;
   logic [3:0]        r_wait;
   logic              r_hreadyout;
   logic              r_hresp;
   logic [31:0]       r_mem [0:(2**MEM_AW)-1];

   logic [31:0]       w_off;
   logic              w_accept;
   logic              w_err;
   logic              w_complete;
   logic [3:0]        w_be;
   logic              w_unused;

   // Window offset; anything above the window's byte bits means out of range
   assign w_off      = HADDR - BASE_ADDR;
   assign w_accept   = HSEL & HREADY & HTRANS[1];
   assign w_err      = (HSIZE > 3'd2) || (w_off[31:MEM_AW+2] != '0) ||
                       (HSIZE == 3'd1 && HADDR[0]) ||
                       (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
   assign w_complete = (r_state == S_DATA) && (r_wait == 4'd0);
   assign w_unused   = ^{HBURST, HTRANS[0]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_write     <= 1'b0;
         r_size      <= 2'd0;
         r_wait      <= 4'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= w_off[MEM_AW+1:0];
         r_write <= HWRITE;
         r_size  <= HSIZE[1:0];
         if (w_err) begin
            r_state     <= S_ERR1;
            r_wait      <= 4'd0;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
         end else begin
            r_state     <= S_DATA;
            r_wait      <= LP_WS;
            r_hreadyout <= (LP_WS == 4'd0);
            r_hresp     <= 1'b0;
         end
      end else begin
         case (r_state)
            S_ERR1: begin
               r_state     <= S_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b1;
            end
            S_DATA: begin
               if (r_wait != 4'd0) begin
                  r_wait      <= r_wait - 4'd1;
                  r_hreadyout <= (r_wait == 4'd1);
               end else begin
                  r_state     <= S_IDLE;
                  r_hreadyout <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_be = 4'b1111;
      case (r_size)
         2'd0:    w_be = 4'b0001 << r_addr[1:0];
         2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   // Commit on the completing edge so a following read's data phase already sees it
   always_ff @(posedge HCLK) begin
      if (w_complete && r_write) begin
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[r_addr[MEM_AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
   end

   assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[r_addr[MEM_AW+1:2]] : 32'd0;
   assign HREADYOUT = r_hreadyout;
   assign HRESP     = r_hresp;

`ifdef AHB_SRAM_STATS_EN
   logic [15:0] r_rd_cnt;
   logic [15:0] r_wr_cnt;
   logic [15:0] r_err_cnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_rd_cnt  <= 16'd0;
         r_wr_cnt  <= 16'd0;
         r_err_cnt <= 16'd0;
      end else begin
         if (w_complete && !r_write && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
         if (w_complete && r_write && r_wr_cnt != 16'hFFFF)  r_wr_cnt <= r_wr_cnt + 16'd1;
         if (w_accept && w_err && r_err_cnt != 16'hFFFF)     r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign stat_rd_cnt  = r_rd_cnt;
   assign stat_wr_cnt  = r_wr_cnt;
   assign stat_err_cnt = r_err_cnt;
`else
   assign stat_rd_cnt  = 16'd0;
   assign stat_wr_cnt  = 16'd0;
   assign stat_err_cnt = 16'd0;
`endif
endmodule
